// File: rtl/pi1_bist_pkg.sv
// Shared definitions for the pi1 bus self-test initiator: bus op codes,
// a constant log2 helper and the controller state encoding.
package pi1_bist_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FINI  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/pi1_bist.sv
// pi1 memory-bus self-test initiator: four-phase write/read/compare march
// over the responder address space, reporting pass, first failing word and count.
module pi1_bist
  import pi1_bist_pkg::*;
#(
  parameter int unsigned ARCHBITSZ   = 32,
  parameter logic [ARCHBITSZ-1:0] SEED = ARCHBITSZ'(32'h5A5A_A5A5),
  parameter int unsigned ERRCNTBITSZ = 8,
  parameter bit          HALTONERR   = 1'b0,
  localparam int unsigned ADDRBITSZ  = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int unsigned SELBITSZ   = ARCHBITSZ / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ADDRBITSZ-1:0]   err_addr_o,
  output logic [ERRCNTBITSZ-1:0] err_cnt_o,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [SELBITSZ-1:0]    pi1_sel_o,
  input  logic                   pi1_rdy_i,
  input  logic [ADDRBITSZ-1:0]   pi1_mapsz_i
);

  bist_state_e            state_q, state_d;
  logic [1:0]             phase_q, phase_d;
  logic [ADDRBITSZ-1:0]   a_q, a_d;
  logic [ADDRBITSZ-1:0]   size_q, size_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [ADDRBITSZ-1:0]   err_addr_q, err_addr_d;
  logic [ERRCNTBITSZ-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]             op_q, op_d;
  logic [ADDRBITSZ-1:0]   addr_q, addr_d;
  logic [ARCHBITSZ-1:0]   data_q, data_d;
  logic [SELBITSZ-1:0]    sel_q, sel_d;

  logic                   last_c;
  logic                   mismatch_c;
  logic [ADDRBITSZ-1:0]   next_a_c;
  logic [1:0]             next_phase_c;

  // Phases 2 and 3 use the inverted pattern.
  function automatic logic [ARCHBITSZ-1:0] pattern(input logic [1:0] ph,
                                                   input logic [ADDRBITSZ-1:0] a);
    return (SEED ^ ARCHBITSZ'(a)) ^ {ARCHBITSZ{ph[1]}};
  endfunction

  // Read phases compare against the data register, which still holds the expected word.
  assign last_c       = (a_q == size_q - ADDRBITSZ'(1));
  assign mismatch_c   = phase_q[0] && (pi1_data_i != data_q);
  assign next_a_c     = last_c ? '0 : a_q + ADDRBITSZ'(1);
  assign next_phase_c = last_c ? phase_q + 2'd1 : phase_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    a_d        = a_q;
    size_d     = size_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;

    case (state_q)
      ST_IDLE: begin
        op_d  = PINOOP;
        sel_d = '0;
        if (start_i) begin
          size_d     = pi1_mapsz_i;
          err_cnt_d  = '0;
          err_addr_d = '0;
          pass_d     = 1'b1;
          phase_d    = 2'd0;
          a_d        = '0;
          if (pi1_mapsz_i == '0) begin
            state_d = ST_FINI;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_ISSUE;
            busy_d  = 1'b1;
            op_d    = PIWROP;
            addr_d  = '0;
            data_d  = pattern(2'd0, '0);
            sel_d   = '1;
          end
        end
      end

      ST_ISSUE: begin
        if (pi1_rdy_i) begin
          state_d = ST_WAIT;
          op_d    = PINOOP;
        end
      end

      ST_WAIT: begin
        if (pi1_rdy_i) begin
          if (mismatch_c) begin
            pass_d = 1'b0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNTBITSZ'(1);
            if (pass_q) err_addr_d = a_q;
          end
          if ((HALTONERR && mismatch_c) || (last_c && phase_q == 2'd3)) begin
            state_d = ST_FINI;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sel_d   = '0;
          end else begin
            state_d = ST_ISSUE;
            a_d     = next_a_c;
            phase_d = next_phase_c;
            op_d    = next_phase_c[0] ? PIRDOP : PIWROP;
            addr_d  = next_a_c;
            data_d  = pattern(next_phase_c, next_a_c);
            sel_d   = '1;
          end
        end
      end

      ST_FINI: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      phase_q    <= 2'd0;
      a_q        <= '0;
      size_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      op_q       <= PINOOP;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      a_q        <= a_d;
      size_q     <= size_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
  assign pi1_op_o   = op_q;
  assign pi1_addr_o = addr_q;
  assign pi1_data_o = data_q;
  assign pi1_sel_o  = sel_q;

endmodule

// File: tb/tb_pi1_bist.sv
// Bench for pi1_bist: two instances (HALTONERR 0 and 1), each on a small
// memory responder with programmable delay and a stuck-at-0 bit on word 2.
module tb_pi1_bist;
  import pi1_bist_pkg::*;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] SEED = 32'h5A5A_A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start [2];
  logic          busy [2];
  logic          done [2];
  logic          pass [2];
  logic [AW-1:0] err_addr [2];
  logic [7:0]    err_cnt [2];
  logic [1:0]    op [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata [2];
  logic [3:0]    sel [2];
  logic          rdy [2];
  logic [AW-1:0] mapsz [2];
  int            dly [2];
  bit            stuck [2];
  int            acc [2];

  int ncmp = 0;
  int nfail = 0;

  for (genvar g = 0; g < 2; g++) begin : gen_u
    int            wcnt = 0;
    int            acc_l = 0;
    logic [3:0]    lat = '0;
    logic [DW-1:0] mem [16];

    pi1_bist #(.HALTONERR(1'(g))) u_dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start[g]),
      .busy_o(busy[g]), .done_o(done[g]), .pass_o(pass[g]),
      .err_addr_o(err_addr[g]), .err_cnt_o(err_cnt[g]),
      .pi1_op_o(op[g]), .pi1_addr_o(addr[g]), .pi1_data_o(wdata[g]),
      .pi1_data_i(rdata[g]), .pi1_sel_o(sel[g]), .pi1_rdy_i(rdy[g]),
      .pi1_mapsz_i(mapsz[g])
    );

    // Responder: accepts when ready, then holds rdy low for dly cycles.
    assign rdy[g]   = (wcnt == 0);
    assign rdata[g] = mem[lat] & ~{31'b0, (stuck[g] && lat == 4'd2)};
    assign acc[g]   = acc_l;

    always @(posedge clk) begin
      if (wcnt != 0) wcnt <= wcnt - 1;
      else if (op[g] != PINOOP) begin
        wcnt  <= dly[g];
        lat   <= addr[g][3:0];
        acc_l <= acc_l + 1;
        if (op[g] == PIWROP) mem[addr[g][3:0]] <= wdata[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference march: memory returns what was written except the stuck bit.
  task automatic model(input int size, input bit halt, input bit stk,
                       output bit xpass, output int xea, output int xec, output int xx);
    logic [DW-1:0] expv, got;
    xpass = 1'b1; xea = 0; xec = 0; xx = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int a = 0; a < size; a++) begin
        xx++;
        if (ph % 2 == 1) begin
          expv = SEED ^ DW'(a);
          if (ph >= 2) expv = ~expv;
          got = expv;
          if (stk && a == 2) got[0] = 1'b0;
          if (got != expv) begin
            if (xpass) xea = a;
            xpass = 1'b0;
            if (xec < 255) xec++;
            if (halt) return;
          end
        end
      end
    end
  endtask

  task automatic run(input int g, input int size, input int d, input bit stk, input bit poke);
    bit xpass;
    int xea, xec, xx, xn, n, a0;
    model(size, g == 1, stk, xpass, xea, xec, xx);
    xn = xx * (d + 2);
    @(negedge clk);
    dly[g] = d; stuck[g] = stk; mapsz[g] = AW'(size); start[g] = 1'b1;
    a0 = acc[g];
    @(posedge clk);
    #1 start[g] = 1'b0;
    n = 0;
    while (!done[g] && n < xn + 20) begin
      @(posedge clk);
      #1 n++;
      if (poke && xn > 8 && n == 3) start[g] = 1'b1;
      if (n == 4) start[g] = 1'b0;
    end
    start[g] = 1'b0;
    chk("done_cycle", 64'(n), 64'(xn));
    chk("busy_at_done", 64'(busy[g]), 64'd0);
    chk("pass", 64'(pass[g]), 64'(xpass));
    chk("err_addr", 64'(err_addr[g]), 64'(xea));
    chk("err_cnt", 64'(err_cnt[g]), 64'(xec));
    chk("xfers", 64'(acc[g] - a0), 64'(xx));
    repeat (3) @(posedge clk);
    #1;
    chk("xfers_after_done", 64'(acc[g] - a0), 64'(xx));
    chk("done_pulse", 64'(done[g]), 64'd0);
    chk("pass_held", 64'(pass[g]), 64'(xpass));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    start = '{1'b0, 1'b0};
    mapsz = '{'0, '0};
    dly   = '{0, 0};
    stuck = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_op", 64'(op[g]), 64'(PINOOP));
      chk("rst_addr", 64'(addr[g]), 64'd0);
      chk("rst_data", 64'(wdata[g]), 64'd0);
      chk("rst_sel", 64'(sel[g]), 64'd0);
      chk("rst_flags", 64'({busy[g], done[g], pass[g]}), 64'd0);
      chk("rst_err", 64'({err_addr[g], err_cnt[g]}), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    run(0, 4, 0, 1'b0, 1'b0);   // clean run
    run(0, 4, 2, 1'b0, 1'b1);   // delayed responder, start pulsed while busy
    run(0, 4, 0, 1'b1, 1'b0);   // stuck bit, run to completion
    run(1, 4, 0, 1'b1, 1'b0);   // stuck bit, halt on first mismatch
    run(1, 4, 3, 1'b1, 1'b0);
    run(0, 0, 0, 1'b0, 1'b0);   // zero size
    run(1, 0, 1, 1'b0, 1'b0);
    run(0, 1, 0, 1'b0, 1'b0);   // single word
    run(0, 16, 1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(1, 0)), int'($urandom_range(16, 1)),
          int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b1);
    end

    // Reset during phase 2: bus drops to NOOP at once and stays quiet.
    @(negedge clk);
    dly[0] = 0; stuck[0] = 1'b0; mapsz[0] = AW'(4); start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1 a0 = acc[0];
    chk("mid_busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_op", 64'(op[0]), 64'(PINOOP));
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_xfers", 64'(acc[0] - a0), 64'd0);
    chk("mid_rst_op_after", 64'(op[0]), 64'(PINOOP));
    run(0, 4, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
